led_tx_serializer: RTL and testbench

LED_TX_SERIALIZER -- requirements
Module: led_tx_serializer

---
 rtl/led_tx_serializer.sv | 188 ++++++++++++++++++
 tb/tb_led_tx_serializer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_tx_serializer.sv
// Serialises 12-bit RGB FIFO words into GRB LED bit-pulses, then holds a latch-low gap.
// Latency: first high pulse 3 cycles after send_start; done 3 + bit-time + TRST cycles after it.
// Backpressure: reads at most PIXEL_NUM words; an empty FIFO when a pixel is due ends the frame with underrun.
module led_tx_serializer #(
  parameter int PIXEL_NUM = 35,
  parameter int T0H       = 20,
  parameter int T0L       = 43,
  parameter int T1H       = 40,
  parameter int T1L       = 23,
  parameter int TRST      = 3000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        send_start,
  input  logic        fifo_empty,
  input  logic [11:0] fifo_rdata,
  output logic        fifo_rd,
  output logic        led_dout,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = imax(imax(imax(T0H, T0L), imax(T1H, T1L)), TRST);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = $clog2(PIXEL_NUM + 1);

  // Terminal counts: a phase lasting N cycles ends when the timer reads N-1.
  localparam logic [TW-1:0] T0H_END  = TW'(T0H - 1);
  localparam logic [TW-1:0] T0L_END  = TW'(T0L - 1);
  localparam logic [TW-1:0] T1H_END  = TW'(T1H - 1);
  localparam logic [TW-1:0] T1L_END  = TW'(T1L - 1);
  localparam logic [TW-1:0] TRST_END = TW'(TRST - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(PIXEL_NUM);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, BIT_HIGH, BIT_LOW, LATCH, DONE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmr;
  logic [PW-1:0] pix_cnt;      // words read from the FIFO this frame
  logic [4:0]    bit_idx;
  logic [23:0]   shreg;        // current pixel, MSB is the bit on the line
  logic [23:0]   shadow;       // prefetched next pixel
  logic          shadow_vld;
  logic          pf_pend;      // prefetch read issued last cycle, data on fifo_rdata now
  logic          tmr_end;
  logic          pf_rd;
  logic          more_pix;
  logic          next_rdy;

  // {R,G,B} nibbles -> GRB order with each nibble repeated to fill a byte.
  function automatic logic [23:0] grb_expand(input logic [11:0] rgb);
    logic [3:0] r, g, b;
    r = rgb[11:8];
    g = rgb[7:4];
    b = rgb[3:0];
    return {g, g, r, r, b, b};
  endfunction

  assign more_pix = (pix_cnt < PIX_LAST);
  assign next_rdy = shadow_vld | pf_pend;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and Moore/strobe outputs; fifo_rd is gated by fifo_empty so it never reads an empty FIFO
  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    led_dout  = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    tmr_end   = 1'b0;
    pf_rd     = 1'b0;
    case (state)
      IDLE: begin
        if (send_start) state_nxt = FETCH;
      end
      FETCH: begin
        if (fifo_empty) begin
          state_nxt = LATCH;
        end else begin
          fifo_rd   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = BIT_HIGH;
      end
      BIT_HIGH: begin
        led_dout = 1'b1;
        tmr_end  = (tmr == (shreg[23] ? T1H_END : T0H_END));
        if (tmr_end) state_nxt = BIT_LOW;
      end
      BIT_LOW: begin
        tmr_end = (tmr == (shreg[23] ? T1L_END : T0L_END));
        pf_rd   = (bit_idx == 5'd0) && (tmr == '0) && more_pix && !fifo_empty;
        fifo_rd = pf_rd;
        if (tmr_end) state_nxt = ((bit_idx != 5'd0) || next_rdy) ? BIT_HIGH : LATCH;
      end
      LATCH: begin
        tmr_end = (tmr == TRST_END);
        if (tmr_end) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Phase timer: counts inside timed phases and returns to zero at every phase boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmr <= '0;
    end else if (((state == BIT_HIGH) || (state == BIT_LOW) || (state == LATCH)) && !tmr_end) begin
      tmr <= tmr + TW'(1);
    end else begin
      tmr <= '0;
    end
  end

  // Pixel datapath: load, shift, prefetch into the shadow, and the sticky underrun flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      shadow     <= '0;
      shadow_vld <= 1'b0;
      pf_pend    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      pf_pend <= pf_rd;
      if (pf_pend) begin
        shadow     <= grb_expand(fifo_rdata);
        shadow_vld <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (send_start) begin
            underrun   <= 1'b0;
            pix_cnt    <= '0;
            shadow_vld <= 1'b0;
          end
        end
        FETCH: begin
          if (fifo_empty) underrun <= 1'b1;
        end
        LOAD: begin
          shreg   <= grb_expand(fifo_rdata);
          bit_idx <= 5'd23;
          pix_cnt <= pix_cnt + PW'(1);
        end
        BIT_LOW: begin
          if (pf_rd) pix_cnt <= pix_cnt + PW'(1);
          if (tmr_end) begin
            if (bit_idx != 5'd0) begin
              shreg   <= {shreg[22:0], 1'b0};
              bit_idx <= bit_idx - 5'd1;
            end else if (pf_pend) begin
              // Very short low time: word arrives on the last low cycle, bypass the shadow.
              shreg      <= grb_expand(fifo_rdata);
              bit_idx    <= 5'd23;
              shadow_vld <= 1'b0;
            end else if (shadow_vld) begin
              shreg      <= shadow;
              bit_idx    <= 5'd23;
              shadow_vld <= 1'b0;
            end else if (more_pix) begin
              underrun <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_tx_serializer.sv
// Directed bench for led_tx_serializer: one instance with PIXEL_NUM=1 and default timing,
// one with PIXEL_NUM=35 and short timing; a mux picks which one the FIFO model and
// line decoder are attached to.
module tb_led_tx_serializer;

  localparam int A_T0H = 20, A_T0L = 43, A_T1H = 40, A_T1L = 23, A_TRST = 3000;
  localparam int B_T0H = 3,  B_T0L = 7,  B_T1H = 6,  B_T1L = 5,  B_TRST = 50;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic        start = 1'b0;
  logic        sel   = 1'b0;
  logic        fifo_empty;
  logic [11:0] fifo_rdata = '0;

  logic a_start, a_rd, a_dout, a_busy, a_done, a_unr;
  logic b_start, b_rd, b_dout, b_busy, b_done, b_unr;
  logic m_rd, m_dout, m_busy, m_done, m_unr;

  assign a_start = start & ~sel;
  assign b_start = start & sel;
  assign m_rd    = sel ? b_rd   : a_rd;
  assign m_dout  = sel ? b_dout : a_dout;
  assign m_busy  = sel ? b_busy : a_busy;
  assign m_done  = sel ? b_done : a_done;
  assign m_unr   = sel ? b_unr  : a_unr;

  always #5 clk = ~clk;

  led_tx_serializer #(.PIXEL_NUM(1)) u_dut_a (
    .clk(clk), .rstn(rstn), .send_start(a_start), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_rd(a_rd), .led_dout(a_dout), .busy(a_busy),
    .done(a_done), .underrun(a_unr)
  );

  led_tx_serializer #(.PIXEL_NUM(35), .T0H(B_T0H), .T0L(B_T0L), .T1H(B_T1H),
                      .T1L(B_T1L), .TRST(B_TRST)) u_dut_b (
    .clk(clk), .rstn(rstn), .send_start(b_start), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_rd(b_rd), .led_dout(b_dout), .busy(b_busy),
    .done(b_done), .underrun(b_unr)
  );

  // FIFO model: data appears the cycle after the read strobe
  logic [11:0] mem [0:127];
  int wptr = 0;
  int rptr = 0;
  assign fifo_empty = (wptr == rptr);

  initial forever begin
    @(posedge clk);
    if (m_rd && (wptr != rptr)) begin
      fifo_rdata <= mem[rptr % 128];
      rptr       <= rptr + 1;
    end
  end

  task automatic push(input logic [11:0] w);
    mem[wptr % 128] = w;
    wptr = wptr + 1;
  endtask

  // Line decoder: classifies each high/low pair by its exact widths
  int t0h = A_T0H, t0l = A_T0L, t1h = A_T1H, t1l = A_T1L, trst = A_TRST;
  logic mon_clr = 1'b0;
  int cyc = 0, t_start = 0, t_done = 0, done_cnt = 0, rd_cnt = 0, rd_viol = 0;
  int hi_seen = 0, bit_cnt = 0, bad_tim = 0, hi_run = 0, lo_run = 0, last_hi = 0;
  logic prev_dout = 1'b0, have_bit = 1'b0, start_seen = 1'b0;
  logic [23:0] cur_word = '0;
  logic [23:0] dec_word [0:63];

  task automatic decode_bit(input int lo);
    logic b;
    if (last_hi == t1h && lo == t1l)      b = 1'b1;
    else if (last_hi == t0h && lo == t0l) b = 1'b0;
    else begin b = 1'b0; bad_tim++; end
    cur_word = {cur_word[22:0], b};
    bit_cnt++;
    if (bit_cnt % 24 == 0) dec_word[(bit_cnt / 24 - 1) % 64] = cur_word;
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_clr) begin
      cyc = 0; t_start = 0; t_done = 0; done_cnt = 0; rd_cnt = 0; rd_viol = 0;
      hi_seen = 0; bit_cnt = 0; bad_tim = 0; hi_run = 0; lo_run = 0; last_hi = 0;
      prev_dout = 1'b0; have_bit = 1'b0; start_seen = 1'b0; cur_word = '0;
    end else begin
      cyc++;
      if (start && !m_busy && !start_seen) begin t_start = cyc; start_seen = 1'b1; end
      if (m_rd) begin rd_cnt++; if (fifo_empty) rd_viol++; end
      if (m_dout) begin
        if (!prev_dout) begin
          hi_seen++;
          if (have_bit) decode_bit(lo_run);
          hi_run = 1;
        end else hi_run++;
      end else begin
        if (prev_dout) begin last_hi = hi_run; have_bit = 1'b1; lo_run = 1; end
        else lo_run++;
      end
      if (m_done) begin
        done_cnt++;
        t_done = cyc;
        // The last bit's low merges with the latch and the done cycle.
        if (have_bit) begin decode_bit(lo_run - trst - 1); have_bit = 1'b0; end
      end
      prev_dout = m_dout;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin tick(1); n++; end
    check({tag, "_done_seen"}, (done_cnt != 0) ? 1 : 0, 1);
    check({tag, "_busy_after"}, int'(m_busy), 0);
  endtask

  task automatic use_b_timing();
    sel = 1'b1; t0h = B_T0H; t0l = B_T0L; t1h = B_T1H; t1l = B_T1L; trst = B_TRST;
  endtask

  function automatic logic [23:0] grb(input logic [11:0] x);
    logic [3:0] r, g, b;
    r = x[11:8]; g = x[7:4]; b = x[3:0];
    return {g, g, r, r, b, b};
  endfunction

  function automatic int word_len(input logic [23:0] w);
    int ones = $countones(w);
    return ones * (t1h + t1l) + (24 - ones) * (t0h + t0l);
  endfunction

  function automatic logic [11:0] pat(input int i);
    return 12'((i * 389 + 77) % 4096);
  endfunction

  initial begin
    int exp_len;
    int bad_px;
    int n;

    // Reset state
    tick(3);
    check("rst_dout", int'(m_dout), 0);
    check("rst_busy", int'(m_busy), 0);
    check("rst_done", int'(m_done), 0);
    check("rst_underrun", int'(m_unr), 0);
    check("rst_fifo_rd", int'(m_rd), 0);
    rstn = 1'b1;
    tick(5);
    check("idle_busy", int'(m_busy), 0);

    // Single pixel 0xF05 -> 0x00FF55
    clear_mon();
    push(12'hF05);
    pulse_start();
    wait_done("px1", 6000);
    check("px1_bits", bit_cnt, 24);
    check("px1_word", int'(dec_word[0]), 'h00FF55);
    check("px1_timing", bad_tim, 0);
    check("px1_rd", rd_cnt, 1);
    check("px1_len", t_done - t_start, 4515);
    check("px1_underrun", int'(m_unr), 0);
    tick(10);
    check("px1_done_cnt", done_cnt, 1);

    // Empty FIFO at start: straight to latch
    clear_mon();
    pulse_start();
    wait_done("empty", 4000);
    check("empty_rd", rd_cnt, 0);
    check("empty_hi_pulses", hi_seen, 0);
    check("empty_underrun", int'(m_unr), 1);
    check("empty_len", t_done - t_start, 3002);
    check("empty_rd_while_empty", rd_viol, 0);

    // Repeated start pulses during a frame are ignored
    clear_mon();
    push(12'h3A7);
    pulse_start();
    check("rep_underrun_cleared", int'(m_unr), 0);
    for (int k = 0; k < 5; k++) begin
      tick(700);
      pulse_start();
    end
    wait_done("rep", 3000);
    tick(50);
    check("rep_done_cnt", done_cnt, 1);
    check("rep_rd", rd_cnt, 1);
    check("rep_word", int'(dec_word[0]), 'hAA3377);
    check("rep_len", t_done - t_start, 4515);
    check("rep_idle", int'(m_busy), 0);

    // Two words for a 35-pixel frame: underrun after pixel 2
    use_b_timing();
    clear_mon();
    push(12'h5C1);
    push(12'hE2B);
    pulse_start();
    wait_done("short", 2000);
    check("short_bits", bit_cnt, 48);
    check("short_w0", int'(dec_word[0]), 'hCC5511);
    check("short_w1", int'(dec_word[1]), 'h22EEBB);
    check("short_timing", bad_tim, 0);
    check("short_rd", rd_cnt, 2);
    check("short_underrun", int'(m_unr), 1);
    exp_len = 3 + word_len(24'hCC5511) + word_len(24'h22EEBB) + B_TRST;
    check("short_len", t_done - t_start, exp_len);
    tick(20);
    check("short_underrun_hold", int'(m_unr), 1);
    check("short_done_cnt", done_cnt, 1);

    // Reset during bit 10 of pixel 3
    wptr = rptr;
    clear_mon();
    for (int i = 0; i < 35; i++) push(pat(i));
    pulse_start();
    tick(1);
    check("mid_underrun_cleared", int'(m_unr), 0);
    n = 0;
    while (bit_cnt < 58 && n < 2000) begin tick(1); n++; end
    check("mid_reached_bit", (bit_cnt >= 58) ? 1 : 0, 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_dout", int'(m_dout), 0);
    check("mid_rst_busy", int'(m_busy), 0);
    tick(5);
    check("mid_rst_rd", rd_cnt, 3);
    check("mid_rst_done", done_cnt, 0);
    rstn = 1'b1;
    tick(5);
    check("mid_idle", int'(m_busy), 0);
    check("mid_idle_rd", rd_cnt, 3);

    // Clean full frame of 35 pixels after the reset
    wptr = rptr;
    clear_mon();
    for (int i = 0; i < 35; i++) push(pat(i));
    pulse_start();
    wait_done("full", 12000);
    bad_px  = 0;
    exp_len = 3 + B_TRST;
    for (int i = 0; i < 35; i++) begin
      if (dec_word[i] != grb(pat(i))) bad_px++;
      exp_len += word_len(grb(pat(i)));
    end
    check("full_bits", bit_cnt, 840);
    check("full_words", bad_px, 0);
    check("full_timing", bad_tim, 0);
    check("full_rd", rd_cnt, 35);
    check("full_underrun", int'(m_unr), 0);
    check("full_len", t_done - t_start, exp_len);
    check("full_rd_while_empty", rd_viol, 0);
    tick(20);
    check("full_done_cnt", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
